// File: rtl/sb_master_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sb_master_if -- SB bus initiator
//
// Turns one user command (start word address, burst size code, direction)
// into a complete SB bus burst. Handles bus request/grant, OKAY / ERROR /
// SPLIT responses, split resume and re-arbitration after a lost grant.
// Write data is taken one beat at a time from a valid/ready style port and
// read data is returned one beat at a time with a single-cycle valid pulse.
//
// Optional build macro:
//   SB_MASTER_TIMEOUT_EN  enables a 16-bit watchdog; when it reaches
//                         TIMEOUT_CYCLES in REQ/XFER/SPLIT_WAIT the command
//                         finishes with err=1. Undefined: waits forever.
//
// Parameters:
//   MASTER_ID       value driven on sb_master; 1 -> listen to sb_split[0],
//                   0 -> listen to sb_split[1]
//   LOCK_BURSTS     1 -> sb_mastlock asserted during multi-beat bursts
//   TIMEOUT_CYCLES  watchdog limit (only used with SB_MASTER_TIMEOUT_EN)
//
// Ports:
//   sb_clk, sb_reset        clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_write, cmd_addr, cmd_size
//   wr_data/wr_valid        write beat source; wr_ready pulses per beat done
//   rd_data/rd_valid        read beat sink, valid one cycle after the beat
//   done/err                one-cycle completion pulse, err qualifies it
//   sb_busreq/sb_grant      arbitration
//   sb_mastlock, sb_master  lock and master id
//   sb_addr, sb_write, sb_trans, sb_size, sb_burst, sb_wdata  bus controls
//   sb_ready, sb_resp, sb_rdata, sb_split                   slave side
// -----------------------------------------------------------------------------
module sb_master_if #(
  parameter int MASTER_ID      = 1,
  parameter int LOCK_BURSTS    = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        sb_clk,
  input  logic        sb_reset,
  // user command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  // user data ports
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  // SB bus
  output logic        sb_busreq,
  input  logic        sb_grant,
  output logic        sb_mastlock,
  output logic        sb_master,
  output logic [31:0] sb_addr,
  output logic        sb_write,
  output logic [1:0]  sb_trans,
  output logic [2:0]  sb_size,
  output logic [2:0]  sb_burst,
  output logic [31:0] sb_wdata,
  input  logic        sb_ready,
  input  logic [1:0]  sb_resp,
  input  logic [31:0] sb_rdata,
  input  logic [1:0]  sb_split
);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [1:0] RESP_OKAY  = 2'd1;
  localparam logic [1:0] RESP_ERROR = 2'd2;
  localparam logic [1:0] RESP_SPLIT = 2'd3;

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("sb_master_if: TIMEOUT_CYCLES out of range 1..65536");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_SPLIT_WAIT,
    ST_FIN
  } state_t;

  state_t      state_reg,      state_next;
  logic        write_reg,      write_next;
  logic [31:0] base_reg,       base_next;
  logic [2:0]  size_reg,       size_next;
  logic [5:0]  beat_idx_reg,   beat_idx_next;
  logic [5:0]  beat_total_reg, beat_total_next;
  logic        first_reg,      first_next;
  logic        err_reg,        err_next;
  logic [31:0] rd_data_reg,    rd_data_next;
  logic        rd_valid_reg,   rd_valid_next;

  logic        in_xfer;
  logic        busy_beat;
  logic        beat_ok;
  logic        last_beat;
  logic        own_split;
  logic        tmo_hit;
  logic [5:0]  beats_left_m1;

  // Burst code to beat count; codes 000/001 are illegal and decode to 0.
  function automatic logic [5:0] decode_size(input logic [2:0] code);
    logic [5:0] beats;
    case (code)
      3'b010:  beats = 6'd1;
      3'b011:  beats = 6'd2;
      3'b100:  beats = 6'd3;
      3'b101:  beats = 6'd8;
      3'b110:  beats = 6'd16;
      3'b111:  beats = 6'd32;
      default: beats = 6'd0;
    endcase
    return beats;
  endfunction

  assign in_xfer   = (state_reg == ST_XFER);
  // A write beat without data is shown as BUSY and never counts.
  assign busy_beat = in_xfer && write_reg && !wr_valid;
  assign beat_ok   = in_xfer && !busy_beat && sb_ready && (sb_resp == RESP_OKAY);
  assign last_beat = ((beat_idx_reg + 6'd1) == beat_total_reg);
  assign own_split = (MASTER_ID != 0) ? sb_split[0] : sb_split[1];
  // Never underflows in XFER because beat_idx < beat_total there.
  assign beats_left_m1 = beat_total_reg - beat_idx_reg - 6'd1;

`ifdef SB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_reg, tmo_cnt_next;
  logic        tmo_counting;

  assign tmo_counting = (state_reg == ST_REQ) || (state_reg == ST_XFER) ||
                        (state_reg == ST_SPLIT_WAIT);
  assign tmo_hit      = tmo_counting && (tmo_cnt_reg >= TMO_LAST);

  // Counter restarts on every completed beat and every state change.
  always_comb begin
    tmo_cnt_next = 16'd0;
    if (tmo_counting && !beat_ok && (state_next == state_reg) &&
        (tmo_cnt_reg != 16'hFFFF)) begin
      tmo_cnt_next = tmo_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge sb_clk) begin
    if (sb_reset) begin
      tmo_cnt_reg <= 16'd0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    write_next      = write_reg;
    base_next       = base_reg;
    size_next       = size_reg;
    beat_idx_next   = beat_idx_reg;
    beat_total_next = beat_total_reg;
    first_next      = first_reg;
    err_next        = err_reg;
    rd_data_next    = rd_data_reg;
    rd_valid_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          write_next      = cmd_write;
          base_next       = cmd_addr;
          size_next       = cmd_size;
          beat_idx_next   = 6'd0;
          beat_total_next = decode_size(cmd_size);
          if (decode_size(cmd_size) == 6'd0) begin
            err_next   = 1'b1;
            state_next = ST_FIN;
          end else begin
            err_next   = 1'b0;
            state_next = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (sb_grant) begin
          // Every (re)entry into XFER starts with a NONSEQ beat.
          first_next = 1'b1;
          state_next = ST_XFER;
        end
      end

      ST_XFER: begin
        if (beat_ok) begin
          beat_idx_next = beat_idx_reg + 6'd1;
          first_next    = 1'b0;
          if (!write_reg) begin
            rd_data_next  = sb_rdata;
            rd_valid_next = 1'b1;
          end
          if (last_beat) begin
            state_next = ST_FIN;
          end else if (!sb_grant) begin
            state_next = ST_REQ;
          end
        end else if (!busy_beat && (sb_resp == RESP_ERROR)) begin
          err_next   = 1'b1;
          state_next = ST_FIN;
        end else if (!busy_beat && (sb_resp == RESP_SPLIT)) begin
          state_next = ST_SPLIT_WAIT;
        end else if (!sb_grant) begin
          // Lost the bus: the uncompleted beat is retried after re-grant.
          state_next = ST_REQ;
        end
      end

      ST_SPLIT_WAIT: begin
        if (own_split) begin
          state_next = ST_REQ;
        end
      end

      ST_FIN: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (tmo_hit && !beat_ok) begin
      err_next   = 1'b1;
      state_next = ST_FIN;
    end
  end

  always_ff @(posedge sb_clk) begin
    if (sb_reset) begin
      state_reg      <= ST_IDLE;
      write_reg      <= 1'b0;
      base_reg       <= 32'd0;
      size_reg       <= 3'd0;
      beat_idx_reg   <= 6'd0;
      beat_total_reg <= 6'd0;
      first_reg      <= 1'b0;
      err_reg        <= 1'b0;
      rd_data_reg    <= 32'd0;
      rd_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      write_reg      <= write_next;
      base_reg       <= base_next;
      size_reg       <= size_next;
      beat_idx_reg   <= beat_idx_next;
      beat_total_reg <= beat_total_next;
      first_reg      <= first_next;
      err_reg        <= err_next;
      rd_data_reg    <= rd_data_next;
      rd_valid_reg   <= rd_valid_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Bus controls are only driven while transferring; elsewhere they
  // sit at zero so an idle or split-parked master presents a quiet bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready   = (state_reg == ST_IDLE);
    done        = (state_reg == ST_FIN);
    err         = (state_reg == ST_FIN) && err_reg;
    wr_ready    = beat_ok && write_reg;
    rd_data     = rd_data_reg;
    rd_valid    = rd_valid_reg;
    sb_master   = (MASTER_ID != 0);
    sb_busreq   = (state_reg == ST_REQ) || in_xfer;
    sb_mastlock = (LOCK_BURSTS != 0) && in_xfer && (beat_total_reg > 6'd1);
    sb_trans    = TRANS_IDLE;
    sb_addr     = 32'd0;
    sb_write    = 1'b0;
    sb_size     = 3'd0;
    sb_burst    = 3'd0;
    sb_wdata    = 32'd0;

    if (in_xfer) begin
      if (busy_beat) begin
        sb_trans = TRANS_BUSY;
      end else if (first_reg) begin
        sb_trans = TRANS_NONSEQ;
      end else begin
        sb_trans = TRANS_SEQ;
      end
      sb_addr  = base_reg + {26'd0, beat_idx_reg};
      sb_write = write_reg;
      sb_size  = size_reg;
      sb_burst = (beats_left_m1 > 6'd7) ? 3'd7 : beats_left_m1[2:0];
      if (write_reg) begin
        sb_wdata = wr_data;
      end
    end
  end

endmodule

// File: tb/tb_sb_master_if.sv
`timescale 1ns/1ps
// Testbench for sb_master_if: a behavioural SB slave/arbiter with randomized
// wait states, BUSY gaps, grant loss, SPLIT and ERROR, checked against a
// beat-level expectation model (address = base + completed beats, etc.).
module tb_sb_master_if;

  logic        sb_clk;
  logic        sb_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic        sb_busreq;
  logic        sb_grant;
  logic        sb_mastlock;
  logic        sb_master;
  logic [31:0] sb_addr;
  logic        sb_write;
  logic [1:0]  sb_trans;
  logic [2:0]  sb_size;
  logic [2:0]  sb_burst;
  logic [31:0] sb_wdata;
  logic        sb_ready;
  logic [1:0]  sb_resp;
  logic [31:0] sb_rdata;
  logic [1:0]  sb_split;

  int total = 0;
  int bad   = 0;

  localparam int NONE    = -1;
  localparam int P_REQ   = 0;
  localparam int P_XFER  = 1;
  localparam int P_SPLIT = 2;
  localparam int P_FIN   = 3;

  logic [31:0] wdata_fixed;
  bit          wdata_fixed_en;
  int          split_dly_cfg;

  sb_master_if #(
    .MASTER_ID      (1),
    .LOCK_BURSTS    (1),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .sb_clk      (sb_clk),
    .sb_reset    (sb_reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .done        (done),
    .err         (err),
    .sb_busreq   (sb_busreq),
    .sb_grant    (sb_grant),
    .sb_mastlock (sb_mastlock),
    .sb_master   (sb_master),
    .sb_addr     (sb_addr),
    .sb_write    (sb_write),
    .sb_trans    (sb_trans),
    .sb_size     (sb_size),
    .sb_burst    (sb_burst),
    .sb_wdata    (sb_wdata),
    .sb_ready    (sb_ready),
    .sb_resp     (sb_resp),
    .sb_rdata    (sb_rdata),
    .sb_split    (sb_split)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  function automatic int beats_of(input logic [2:0] code);
    case (code)
      3'b010:  return 1;
      3'b011:  return 2;
      3'b100:  return 3;
      3'b101:  return 8;
      3'b110:  return 16;
      3'b111:  return 32;
      default: return 0;
    endcase
  endfunction

  // One full command against the slave model. Beat indices are 0-based;
  // NONE disables a feature. abort_beat asserts sb_reset during that beat.
  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input int grant_dly,
                         input int err_beat, input int split_beat, input int drop_beat,
                         input int busy_beat, input int busy_len, input int busy_pct,
                         input int wait_pct, input int abort_beat);
    int          n, k, phase, dly, busy_left, split_dly, cyc, rem;
    bit          need_nonseq, rd_pend, split_used, drop_used, busy_used;
    bit          errflag, finished, busy, complete, aborted;
    logic [31:0] rd_exp, wd;
    logic [1:0]  exp_trans;
    logic [2:0]  exp_burst;
    logic [11:0] got_v, exp_v;
    logic [16:0] got_r, exp_r;

    n = beats_of(size);
    k = 0; busy_left = 0; split_dly = 0; cyc = 0;
    need_nonseq = 1; rd_pend = 0; split_used = 0; drop_used = 0; busy_used = 0;
    finished = 0; aborted = 0; rd_exp = 32'd0;
    dly = (grant_dly >= 0) ? grant_dly : int'($urandom_range(0, 3));

    @(posedge sb_clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; sb_grant = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s cmd_ready got=%0b exp=1", tag, cmd_ready);
    end
    @(posedge sb_clk); #1;
    // Scramble the command inputs: the master must work from latched copies.
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_size = 3'($urandom);
    phase   = (n == 0) ? P_FIN : P_REQ;
    errflag = (n == 0);

    while (!finished && cyc < 3000) begin
      total++;
      if (rd_valid !== rd_pend || (rd_pend && rd_data !== rd_exp)) begin
        bad++;
        $display("FAIL %s rd_beat k=%0d got valid=%0b data=%h exp valid=%0b data=%h",
                 tag, k, rd_valid, rd_data, rd_pend, rd_exp);
      end
      rd_pend  = 0;
      sb_resp  = 2'd0;
      sb_ready = 1'($urandom);
      sb_rdata = $urandom;
      sb_split = 2'd0;
      wr_valid = 1'($urandom);
      wr_data  = $urandom;

      case (phase)
        P_REQ: begin
          total++;
          if ({done, sb_busreq, sb_trans} !== {1'b0, 1'b1, 2'd0}) begin
            bad++;
            $display("FAIL %s req done/busreq/trans got=%0b%0b%0d exp=010", tag, done, sb_busreq, sb_trans);
          end
          if (dly == 0) begin
            sb_grant = 1'b1; phase = P_XFER;
          end else begin
            sb_grant = 1'b0; dly--;
          end
        end

        P_XFER: begin
          if (k == abort_beat) begin
            sb_reset = 1'b1; aborted = 1; finished = 1;
            sb_ready = 1'b1; sb_resp = 2'd1;
          end else begin
            if (wr && k == busy_beat && !busy_used) begin
              busy_left = busy_len; busy_used = 1;
            end
            busy = wr && (busy_left > 0 || int'($urandom_range(0, 99)) < busy_pct);
            if (busy_left > 0) busy_left--;
            wd = wdata_fixed_en ? wdata_fixed : $urandom;
            wr_data = wd;
            if (wr) wr_valid = !busy;
            #1;
            exp_trans = busy ? 2'd1 : (need_nonseq ? 2'd2 : 2'd3);
            rem = n - k - 1;
            exp_burst = (rem > 7) ? 3'd7 : 3'(rem);
            got_v = {sb_busreq, sb_trans, sb_write, sb_size, sb_burst, sb_mastlock, done};
            exp_v = {1'b1, exp_trans, wr, size, exp_burst, (n > 1), 1'b0};
            total++;
            if (got_v !== exp_v) begin
              bad++;
              $display("FAIL %s xfer_ctrl k=%0d got=%h exp=%h (busreq,trans,write,size,burst,lock,done)",
                       tag, k, got_v, exp_v);
            end
            total++;
            if (sb_addr !== addr + 32'(k)) begin
              bad++; $display("FAIL %s sb_addr k=%0d got=%h exp=%h", tag, k, sb_addr, addr + 32'(k));
            end
            if (wr && !busy) begin
              total++;
              if (sb_wdata !== wd) begin
                bad++; $display("FAIL %s sb_wdata k=%0d got=%h exp=%h", tag, k, sb_wdata, wd);
              end
            end
            complete = 0;
            if (busy) begin
              // An OKAY seen during BUSY must not count as a beat.
              sb_ready = 1'b1; sb_resp = 2'd1;
            end else if (k == err_beat) begin
              sb_ready = 1'b1; sb_resp = 2'd2; errflag = 1; phase = P_FIN;
            end else if (k == split_beat && !split_used) begin
              sb_ready = 1'b1; sb_resp = 2'd3; split_used = 1; need_nonseq = 1;
              split_dly = (split_dly_cfg >= 0) ? split_dly_cfg : int'($urandom_range(0, 6));
              phase = P_SPLIT;
            end else if (k == drop_beat && !drop_used) begin
              sb_grant = 1'b0; sb_ready = 1'b0; drop_used = 1; need_nonseq = 1;
              dly = int'($urandom_range(0, 3)); phase = P_REQ;
            end else if (int'($urandom_range(0, 99)) < wait_pct) begin
              if ($urandom_range(0, 1) == 1) begin
                sb_ready = 1'b0; sb_resp = 2'd1;
              end else begin
                sb_ready = 1'b1; sb_resp = 2'd0;
              end
            end else begin
              sb_ready = 1'b1; sb_resp = 2'd1; complete = 1;
            end
            #1;
            total++;
            if (wr_ready !== (complete && wr)) begin
              bad++; $display("FAIL %s wr_ready k=%0d got=%0b exp=%0b", tag, k, wr_ready, complete && wr);
            end
            if (complete) begin
              if (!wr) begin
                rd_pend = 1; rd_exp = sb_rdata;
              end
              k++; need_nonseq = 0;
              if (k == n) phase = P_FIN;
            end
          end
        end

        P_SPLIT: begin
          total++;
          if ({done, sb_busreq, sb_trans} !== 4'b0000) begin
            bad++;
            $display("FAIL %s split_idle done/busreq/trans got=%0b%0b%0d exp=000", tag, done, sb_busreq, sb_trans);
          end
          sb_grant    = 1'b0;
          sb_split[1] = 1'($urandom);  // another master's release, ignored
          if (split_dly == 0) begin
            sb_split[0] = 1'b1; phase = P_REQ; dly = int'($urandom_range(0, 3));
          end else begin
            split_dly--;
          end
        end

        default: begin
          total++;
          if ({done, err, sb_busreq, sb_trans} !== {1'b1, errflag, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL %s fin done/err/busreq/trans got=%0b%0b%0b%0d exp=1%0b00",
                     tag, done, err, sb_busreq, sb_trans, errflag);
          end
          sb_grant = 1'b0; finished = 1;
        end
      endcase
      if (!finished) begin
        @(posedge sb_clk); #1;
      end
      cyc++;
    end

    if (!finished) begin
      total++; bad++;
      $display("FAIL %s cycle budget expired at beat %0d of %0d", tag, k, n);
    end

    @(posedge sb_clk); #1;
    sb_grant = 1'b0; sb_resp = 2'd0; sb_ready = 1'b0; sb_split = 2'd0; wr_valid = 1'b0;
    if (aborted) begin
      sb_reset = 1'b0;
      got_r = {cmd_ready, sb_master, done, err, wr_ready, rd_valid, sb_busreq, sb_mastlock,
               sb_write, sb_trans, sb_size, sb_burst};
      exp_r = {2'b11, 15'd0};
      total++;
      if (got_r !== exp_r || {sb_addr, sb_wdata, rd_data} !== 96'd0) begin
        bad++;
        $display("FAIL %s after_reset ctrl got=%h exp=%h addr=%h wdata=%h rdata=%h",
                 tag, got_r, exp_r, sb_addr, sb_wdata, rd_data);
      end
      for (int i = 0; i < 3; i++) begin
        @(posedge sb_clk); #1;
        total++;
        if ({done, sb_busreq, cmd_ready} !== 3'b001) begin
          bad++; $display("FAIL %s no_done_after_abort done/busreq/cmd_ready got=%0b%0b%0b exp=001",
                          tag, done, sb_busreq, cmd_ready);
        end
      end
    end else begin
      total++;
      if ({done, cmd_ready, rd_valid, sb_busreq} !== 4'b0100) begin
        bad++; $display("FAIL %s post_fin done/cmd_ready/rd_valid/busreq got=%0b%0b%0b%0b exp=0100",
                        tag, done, cmd_ready, rd_valid, sb_busreq);
      end
    end
    $display("cmd %s wr=%0b addr=%h size=%0d beats_done=%0d err=%0b abort=%0b",
             tag, wr, addr, size, k, errflag, aborted);
  endtask

  task automatic test_reset();
    logic [16:0] got_r;
    sb_reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_size = 3'd0;
    wr_data = 32'd0; wr_valid = 1'b0; sb_grant = 1'b0; sb_ready = 1'b0; sb_resp = 2'd0;
    sb_rdata = 32'd0; sb_split = 2'd0;
    repeat (3) @(posedge sb_clk);
    #1;
    got_r = {cmd_ready, sb_master, done, err, wr_ready, rd_valid, sb_busreq, sb_mastlock,
             sb_write, sb_trans, sb_size, sb_burst};
    total++;
    if (got_r !== {2'b11, 15'd0} || {sb_addr, sb_wdata, rd_data} !== 96'd0) begin
      bad++; $display("FAIL reset_state got=%h exp=%h addr=%h", got_r, {2'b11, 15'd0}, sb_addr);
    end
    sb_reset = 1'b0;
    @(posedge sb_clk); #1;
    total++;
    if ({cmd_ready, done, sb_busreq} !== 3'b100) begin
      bad++; $display("FAIL reset_release got=%b exp=100", {cmd_ready, done, sb_busreq});
    end
    $display("reset checked");
  endtask

  task automatic test_single_write();
    wdata_fixed_en = 1; wdata_fixed = 32'hA5A5_A5A5;
    run_cmd("single_wr", 1'b1, 32'h10, 3'b010, 2, NONE, NONE, NONE, NONE, 0, 0, 0, NONE);
    wdata_fixed_en = 0;
  endtask

  task automatic test_read_burst8();
    run_cmd("rd8", 1'b0, 32'h20, 3'b101, 0, NONE, NONE, NONE, NONE, 0, 0, 0, NONE);
  endtask

  task automatic test_split_write();
    split_dly_cfg = 5;
    run_cmd("split_wr", 1'b1, 32'h40, 3'b100, 1, NONE, 1, NONE, NONE, 0, 0, 0, NONE);
    split_dly_cfg = NONE;
  endtask

  task automatic test_error_read();
    run_cmd("err_rd16", 1'b0, 32'h80, 3'b110, 0, 3, NONE, NONE, NONE, 0, 0, 0, NONE);
  endtask

  task automatic test_busy_write();
    run_cmd("busy_wr", 1'b1, 32'h100, 3'b101, 0, NONE, NONE, NONE, 3, 3, 0, 0, NONE);
  endtask

  task automatic test_grant_drop();
    run_cmd("grant_drop", 1'b0, 32'h200, 3'b100, 1, NONE, NONE, 1, NONE, 0, 0, 0, NONE);
  endtask

  task automatic test_wrap();
    run_cmd("wrap", 1'b1, 32'hFFFF_FFFE, 3'b100, 0, NONE, NONE, NONE, NONE, 0, 10, 10, NONE);
  endtask

  task automatic test_bad_size();
    run_cmd("size000", 1'b0, 32'h400, 3'b000, 0, NONE, NONE, NONE, NONE, 0, 0, 0, NONE);
    run_cmd("size001", 1'b1, 32'h404, 3'b001, 0, NONE, NONE, NONE, NONE, 0, 0, 0, NONE);
  endtask

  task automatic test_reset_mid();
    run_cmd("reset_mid", 1'b0, 32'h300, 3'b111, 0, NONE, NONE, NONE, NONE, 0, 0, 20, 4);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 1'b0, 32'h500, 3'b011, 0, NONE, NONE, NONE, NONE, 0, 0, 0, NONE);
    run_cmd("b2b_b", 1'b1, 32'h600, 3'b011, 0, NONE, NONE, NONE, NONE, 0, 0, 0, NONE);
  endtask

  task automatic test_random();
    logic [2:0]  size;
    logic [31:0] addr;
    int          n, eb, sp, dr;
    for (int t = 0; t < 25; t++) begin
      size = 3'($urandom);
      n    = beats_of(size);
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      eb = (n > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : NONE;
      sp = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : NONE;
      dr = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : NONE;
      run_cmd($sformatf("rand%0d", t), 1'($urandom), addr, size, NONE, eb, sp, dr,
              NONE, 0, 20, 25, NONE);
    end
  endtask

  initial begin
    wdata_fixed_en = 0;
    wdata_fixed    = 32'd0;
    split_dly_cfg  = NONE;
    test_reset();
    test_single_write();
    test_read_burst8();
    test_split_write();
    test_error_read();
    test_busy_write();
    test_grant_drop();
    test_wrap();
    test_bad_size();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sb_master_if.md
Name: sb_master_if

Overview:
- SB bus initiator. Turns single user commands (address, size, direction) into complete SB bus bursts toward the SBslave-class responders through the arbiter/decoder.
- Handles bus request/grant, OKAY/ERROR/SPLIT responses and split resume.
- Delivers read data and accepts write data one beat at a time on a simple valid/ready user port.

Parameters:
- MASTER_ID, 1, value driven on sb_master; selects the split bit (1 -> sb_split[0], 0 -> sb_split[1]).
- LOCK_BURSTS, 0, when 1 assert sb_mastlock for the duration of multi-beat bursts.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with SB_MASTER_TIMEOUT_EN).

Ports:
- sb_clk  in  1  clock.
- sb_reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  start word address.
- cmd_size  in  3  burst code.
- wr_data  in  32  write beat data.
- wr_valid  in  1  wr_data available.
- wr_ready  out  1  pulse: current write beat completed on bus.
- rd_data  out  32  read beat data.
- rd_valid  out  1  pulse: rd_data valid.
- done  out  1  pulse: command finished.
- err  out  1  valid with done: command failed.
- sb_busreq  out  1  bus request to arbiter.
- sb_grant  in  1  bus granted.
- sb_mastlock  out  1  locked transfer.
- sb_master  out  1  master id (= MASTER_ID).
- sb_addr  out  32  beat address.
- sb_write  out  1  direction.
- sb_trans  out  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- sb_size  out  3  latched cmd_size.
- sb_burst  out  3  beats remaining minus 1, saturated at 7.
- sb_wdata  out  32  write data.
- sb_ready  in  1  slave ready.
- sb_resp  in  2  0 = none/wait, OKAY=1, ERROR=2, SPLIT=3.
- sb_rdata  in  32  read data.
- sb_split  in  2  split release bits.

Behaviour:
- Reset (sb_reset=1 at a clock edge, any state, including mid-burst): state IDLE, beat_idx=0.
  - All outputs 0, except cmd_ready=1 and sb_master=MASTER_ID.
  - An aborted burst produces no done pulse.
- Size decode: 010->1, 011->2, 100->3, 101->8, 110->16, 111->32 beats. beat_idx and beat_total are 6 bits.
- States: IDLE, REQ, XFER, SPLIT_WAIT, FIN.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch write, addr, size; beat_idx=0.
  - Size 000/001: go FIN with err=1, no bus activity.
  - Otherwise go REQ.
- REQ:
  - sb_busreq=1, sb_trans=IDLE.
  - On sb_grant=1, go XFER next cycle; the first beat is NONSEQ.
- XFER:
  - sb_busreq=1. sb_addr = base + beat_idx, modulo 2^32 (wraps at 0xFFFFFFFF).
  - sb_trans is NONSEQ on the first beat after entry, otherwise SEQ.
  - Write with wr_valid=0: sb_trans=BUSY, beat not counted, controls held.
  - Beat completes when sb_ready=1, sb_resp=OKAY and sb_trans is not BUSY.
    - beat_idx increments.
    - Write: wr_ready pulses the same cycle.
    - Read: rd_data<=sb_rdata, rd_valid=1 the next cycle (1-cycle latency).
  - Completing the beat_total-th beat: go FIN.
  - sb_resp=0 or sb_ready=0: wait, outputs held.
  - sb_resp=ERROR: go FIN with err=1; remaining beats dropped.
  - sb_resp=SPLIT: beat not counted; sb_busreq=0, sb_trans=IDLE; go SPLIT_WAIT.
  - sb_grant low mid-burst (not split): go REQ; current beat retried as NONSEQ at base+beat_idx.
- SPLIT_WAIT:
  - Bus outputs idle. Own split bit high for one cycle -> REQ.
  - Resume at base+beat_idx with NONSEQ.
  - Remaining beats = beat_total - beat_idx.
- FIN: done=1 for exactly one cycle, sb_busreq=0, go IDLE.
- Simultaneous cases:
  - SPLIT and ERROR cannot coincide (single sb_resp encoding).
  - Split bit already high on entry to SPLIT_WAIT counts as release on the next cycle.
- sb_mastlock = LOCK_BURSTS && state==XFER && beat_total>1.

Optional Feature:
- SB_MASTER_TIMEOUT_EN defined:
  - 16-bit counter clears on every completed beat and on state change.
  - Counts in REQ, XFER and SPLIT_WAIT.
  - Reaching TIMEOUT_CYCLES goes FIN with err=1, drops sb_busreq.
- Undefined: no counter; the master waits indefinitely.

Test Plan:
- Single write, cmd_size=010, addr 0x10, wr_data 0xA5A5A5A5, grant after 2 cycles -> NONSEQ at 0x10, one wr_ready, done=1, err=0.
- 8-beat read, cmd_size=101, addr 0x20, slave OKAY each cycle -> sb_addr 0x20..0x27 (NONSEQ then 7 SEQ), 8 rd_valid pulses with matching data, done.
- 3-beat write with SPLIT on beat 2, sb_split[0] raised 5 cycles later (MASTER_ID=1) -> busreq drops, re-request, NONSEQ at addr+1, beats 2-3 complete, done, err=0.
- 16-beat read with ERROR on beat 4 -> 3 rd_valid pulses, done with err=1, no further bus activity.
- Write with wr_valid low for 3 cycles mid-burst -> sb_trans=BUSY for 3 cycles, no extra wr_ready, address unchanged.
- sb_reset asserted during beat 5 of 32 -> next cycle IDLE, outputs at reset values, no done. With macro, slave never ready, TIMEOUT_CYCLES=64 -> done+err at cycle 64.
